// File: rtl/noc_pkg.sv
// Shared port indices, flit field extraction and XY dimension-order routing for the mesh router.
package noc_pkg;

  localparam int unsigned NPORTS = 5;

  localparam logic [2:0] P_LOCAL   = 3'd0;
  localparam logic [2:0] P_NORTH   = 3'd1;
  localparam logic [2:0] P_SOUTH   = 3'd2;
  localparam logic [2:0] P_EAST    = 3'd3;
  localparam logic [2:0] P_WEST    = 3'd4;
  localparam logic [2:0] P_INVALID = 3'd7;

  // Flits are passed zero-extended to 64 bits so one function serves every FLIT_W.
  function automatic int unsigned flit_row(logic [63:0] flit, int unsigned flit_w,
                                           int unsigned xw);
    logic [63:0] v;
    v = (flit >> (flit_w - xw)) & ((64'd1 << xw) - 64'd1);
    return 32'(v);
  endfunction

  function automatic int unsigned flit_col(logic [63:0] flit, int unsigned flit_w,
                                           int unsigned xw, int unsigned yw);
    logic [63:0] v;
    v = (flit >> (flit_w - xw - yw)) & ((64'd1 << yw) - 64'd1);
    return 32'(v);
  endfunction

  function automatic logic [63:0] flit_payload(logic [63:0] flit, int unsigned flit_w,
                                               int unsigned xw, int unsigned yw);
    return flit & ((64'd1 << (flit_w - xw - yw)) - 64'd1);
  endfunction

  // Columns are resolved before rows; coordinates outside the mesh are reported as invalid.
  function automatic logic [2:0] xy_route(int unsigned row, int unsigned col,
                                          int unsigned x_id, int unsigned y_id,
                                          int unsigned mesh_x, int unsigned mesh_y);
    if (row == 0 || row > mesh_x || col == 0 || col > mesh_y) return P_INVALID;
    if (col > y_id) return P_EAST;
    if (col < y_id) return P_WEST;
    if (row < x_id) return P_NORTH;
    if (row > x_id) return P_SOUTH;
    return P_LOCAL;
  endfunction

endpackage

// File: rtl/router_fifo.sv
// Per-input flit buffer: power-of-two depth, show-ahead head, writes ignored while full.
module router_fifo #(
  parameter int unsigned FLIT_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [FLIT_W-1:0] data_i,
  output logic [FLIT_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [AW:0]       count_q;
  logic              do_push, do_pop;

  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rptr_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/mesh_router_xy.sv
// Five-port single-flit mesh router: buffered inputs, XY routing, per-output round-robin,
// registered outputs and a sticky error flag.
module mesh_router_xy
  import noc_pkg::*;
#(
  parameter int unsigned FLIT_W = 8,
  parameter int unsigned XW     = 2,
  parameter int unsigned YW     = 2,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned MESH_X = 2,
  parameter int unsigned MESH_Y = 2,
  parameter int unsigned X_ID   = 1,
  parameter int unsigned Y_ID   = 1
) (
  input  logic                     rt_clk,
  input  logic                     rt_reset,
  input  logic [5*FLIT_W-1:0]      in_data,
  input  logic [4:0]               in_en,
  output logic [4:0]               in_full,
  output logic [5*FLIT_W-1:0]      out_data,
  output logic [4:0]               out_w,
  input  logic [4:0]               out_n_full,
  output logic                     err
);

  localparam int unsigned NP = NPORTS;

  logic [FLIT_W-1:0] head [NP];
  logic [2:0]        route [NP];
  logic [NP-1:0]     empty, full, push, pop, bad_head, grant_valid;
  logic [2:0]        winner [NP];
  logic [2:0]        ptr_q [NP];
  logic [2:0]        ptr_d [NP];
  logic [NP-1:0]     out_w_q;
  logic [NP*FLIT_W-1:0] out_data_q;
  logic              err_q;

  for (genvar p = 0; p < NP; p++) begin : g_in
    assign push[p] = in_en[p] && !full[p];

    router_fifo #(
      .FLIT_W(FLIT_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_i  (rt_clk),
      .rst_i  (rt_reset),
      .push_i (push[p]),
      .pop_i  (pop[p]),
      .data_i (in_data[p*FLIT_W +: FLIT_W]),
      .head_o (head[p]),
      .full_o (full[p]),
      .empty_o(empty[p])
    );
  end

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      route[i] = xy_route(flit_row(64'(head[i]), FLIT_W, XW),
                          flit_col(64'(head[i]), FLIT_W, XW, YW),
                          X_ID, Y_ID, MESH_X, MESH_Y);
      bad_head[i] = !empty[i] && (route[i] == P_INVALID);
    end
  end

  // Each head names exactly one output, so an input can never win two outputs at once.
  always_comb begin
    logic [3:0] sum;
    logic [2:0] idx;
    sum = '0;
    idx = '0;
    for (int o = 0; o < NP; o++) begin
      grant_valid[o] = 1'b0;
      winner[o]      = '0;
      ptr_d[o]       = ptr_q[o];
      if (!out_n_full[o]) begin
        for (int k = 0; k < NP; k++) begin
          sum = {1'b0, ptr_q[o]} + 4'(k);
          if (sum >= 4'd5) sum = sum - 4'd5;
          idx = sum[2:0];
          if (!grant_valid[o] && !empty[idx] && (route[idx] == 3'(o))) begin
            grant_valid[o] = 1'b1;
            winner[o]      = idx;
            ptr_d[o]       = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
          end
        end
      end
    end
    pop = bad_head;
    for (int o = 0; o < NP; o++) begin
      if (grant_valid[o]) pop[winner[o]] = 1'b1;
    end
  end

  always_ff @(posedge rt_clk or posedge rt_reset) begin
    if (rt_reset) begin
      for (int o = 0; o < NP; o++) ptr_q[o] <= '0;
      out_w_q    <= '0;
      out_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      for (int o = 0; o < NP; o++) begin
        ptr_q[o]   <= ptr_d[o];
        out_w_q[o] <= grant_valid[o];
        if (grant_valid[o]) out_data_q[o*FLIT_W +: FLIT_W] <= head[winner[o]];
      end
      if (|(in_en & full) || |bad_head) err_q <= 1'b1;
    end
  end

  assign in_full  = full;
  assign out_w    = out_w_q;
  assign out_data = out_data_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mesh_router_xy.sv
// Self-checking bench for mesh_router_xy at cell (1,1) of a 2x2 mesh, using a queue-based model.
module tb_mesh_router_xy;

  localparam int D = 4;

  logic        rt_clk = 1'b0;
  logic        rt_reset = 1'b0;
  logic [39:0] in_data = '0;
  logic [4:0]  in_en = '0;
  logic [4:0]  in_full;
  logic [39:0] out_data;
  logic [4:0]  out_w;
  logic [4:0]  out_n_full = '0;
  logic        err;

  int checks = 0;
  int failures = 0;

  // Model state: one queue per input, one round-robin start per output.
  logic [7:0]  q [5][$];
  int          rr [5];
  logic [4:0]  exp_w, exp_full;
  logic [39:0] exp_d;
  logic        exp_err;

  mesh_router_xy #(
    .FLIT_W(8), .XW(2), .YW(2), .DEPTH(4), .MESH_X(2), .MESH_Y(2), .X_ID(1), .Y_ID(1)
  ) dut (
    .rt_clk    (rt_clk),
    .rt_reset  (rt_reset),
    .in_data   (in_data),
    .in_en     (in_en),
    .in_full   (in_full),
    .out_data  (out_data),
    .out_w     (out_w),
    .out_n_full(out_n_full),
    .err       (err)
  );

  always #5 rt_clk = ~rt_clk;

  // Destination port seen from cell (1,1): -1 for an address outside the 2x2 mesh.
  function automatic int route_of(logic [7:0] f);
    int row, col;
    row = int'(f[7:6]);
    col = int'(f[5:4]);
    if (row == 0 || row > 2 || col == 0 || col > 2) return -1;
    if (col > 1) return 3;
    if (row > 1) return 2;
    return 0;
  endfunction

  function automatic logic [39:0] put(int p, logic [7:0] f);
    return 40'(f) << (p * 8);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      q[i].delete();
      rr[i] = 0;
    end
    exp_w = '0; exp_full = '0; exp_d = '0; exp_err = 1'b0;
  endtask

  task automatic model_edge(input logic [4:0] en, input logic [39:0] data,
                            input logic [4:0] nfull);
    bit   popm [5];
    logic [4:0] was_full;
    int   start, i;
    for (int p = 0; p < 5; p++) begin
      popm[p] = 1'b0;
      was_full[p] = (q[p].size() == D);
    end
    exp_w = '0;
    for (int o = 0; o < 5; o++) begin
      start = rr[o];
      if (!nfull[o]) begin
        for (int k = 0; k < 5; k++) begin
          i = (start + k) % 5;
          if (!exp_w[o] && q[i].size() > 0 && route_of(q[i][0]) == o) begin
            exp_w[o] = 1'b1;
            exp_d[o*8 +: 8] = q[i][0];
            popm[i] = 1'b1;
            rr[o] = (i + 1) % 5;
          end
        end
      end
    end
    for (int p = 0; p < 5; p++) begin
      if (q[p].size() > 0 && route_of(q[p][0]) < 0) begin
        popm[p] = 1'b1;
        exp_err = 1'b1;
      end
      if (en[p] && was_full[p]) exp_err = 1'b1;
      if (popm[p]) void'(q[p].pop_front());
      if (en[p] && !was_full[p]) q[p].push_back(data[p*8 +: 8]);
      exp_full[p] = (q[p].size() == D);
    end
  endtask

  task automatic cycle(input logic [4:0] en, input logic [39:0] data, input logic [4:0] nfull);
    in_en = en;
    in_data = data;
    out_n_full = nfull;
    model_edge(en, data, nfull);
    @(posedge rt_clk);
    #1;
    in_en = '0;
  endtask

  task automatic apply_reset();
    rt_reset = 1'b1;
    in_en = '0;
    out_n_full = '0;
    model_reset();
    #2;
    @(negedge rt_clk);
    rt_reset = 1'b0;
    @(posedge rt_clk);
    #1;
  endtask

  task automatic test_reset();
    rt_reset = 1'b1;
    #1;
    checks++;
    if ({out_w, out_data, in_full, err} !== 51'd0) begin
      failures++;
      $display("FAIL reset_assert got w=%h d=%h full=%h err=%b exp all zero",
               out_w, out_data, in_full, err);
    end
    apply_reset();
    checks++;
    if ({out_w, out_data, in_full, err} !== 51'd0) begin
      failures++;
      $display("FAIL reset_release got w=%h d=%h full=%h err=%b exp all zero",
               out_w, out_data, in_full, err);
    end
  endtask

  task automatic test_local_east();
    apply_reset();
    cycle(5'b00001, put(0, 8'hA5), '0);
    checks++;
    if (out_w !== 5'b0) begin
      failures++;
      $display("FAIL east_edge1 got out_w=%b exp 00000", out_w);
    end
    cycle('0, '0, '0);
    checks++;
    if (out_w !== 5'b01000 || out_data[31:24] !== 8'hA5) begin
      failures++;
      $display("FAIL east_edge2 got out_w=%b east=%h exp 01000/a5", out_w, out_data[31:24]);
    end
    cycle('0, '0, '0);
    checks++;
    if (out_w !== 5'b0 || out_data[31:24] !== 8'hA5) begin
      failures++;
      $display("FAIL east_one_cycle got out_w=%b east=%h exp 00000/a5", out_w, out_data[31:24]);
    end
  endtask

  task automatic test_own_dest();
    apply_reset();
    cycle(5'b10000, put(4, 8'h5B), '0);
    cycle('0, '0, '0);
    checks++;
    if (out_w !== 5'b00001 || out_data[7:0] !== 8'h5B) begin
      failures++;
      $display("FAIL own_dest got out_w=%b local=%h exp 00001/5b", out_w, out_data[7:0]);
    end
  endtask

  task automatic test_alternate();
    logic [4:0] en;
    logic       exp_src;
    apply_reset();
    exp_src = 1'b0;
    for (int c = 0; c < 14; c++) begin
      en = {~exp_full[4], 3'b000, 1'b0} | {4'b0000, 1'b0};
      en[1] = ~exp_full[1];
      cycle(en, put(1, {4'hA, 1'b0, 3'(c)}) | put(4, {4'hA, 1'b1, 3'(c)}), '0);
      checks++;
      if ({out_w, out_data, in_full, err} !== {exp_w, exp_d, exp_full, exp_err}) begin
        failures++;
        $display("FAIL alt_model c=%0d got w=%h d=%h f=%h e=%b exp w=%h d=%h f=%h e=%b", c,
                 out_w, out_data, in_full, err, exp_w, exp_d, exp_full, exp_err);
      end
      if (c >= 1) begin
        checks++;
        if (out_w[3] !== 1'b1 || out_data[27] !== exp_src) begin
          failures++;
          $display("FAIL alt_order c=%0d got w3=%b src=%b exp 1/%b", c, out_w[3],
                   out_data[27], exp_src);
        end
        exp_src = ~exp_src;
      end
    end
    for (int c = 0; c < 20; c++) begin
      cycle('0, '0, '0);
      checks++;
      if ({out_w, out_data, in_full} !== {exp_w, exp_d, exp_full}) begin
        failures++;
        $display("FAIL alt_drain c=%0d got w=%h d=%h exp w=%h d=%h", c, out_w, out_data,
                 exp_w, exp_d);
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    for (int n = 0; n < 5; n++) begin
      cycle(5'b00001, put(0, {4'hA, 4'(n)}), 5'b01000);
      if (n == 3) begin
        checks++;
        if (in_full[0] !== 1'b1 || err !== 1'b0) begin
          failures++;
          $display("FAIL bp_full got in_full0=%b err=%b exp 1/0", in_full[0], err);
        end
      end
    end
    checks++;
    if (err !== 1'b1 || out_w !== 5'b0) begin
      failures++;
      $display("FAIL bp_overflow got err=%b out_w=%b exp 1/00000", err, out_w);
    end
    for (int n = 0; n < 4; n++) begin
      cycle('0, '0, '0);
      checks++;
      if (out_w !== 5'b01000 || out_data[31:24] !== {4'hA, 4'(n)}) begin
        failures++;
        $display("FAIL bp_drain n=%0d got w=%b east=%h exp 01000/%h", n, out_w,
                 out_data[31:24], {4'hA, 4'(n)});
      end
    end
    cycle('0, '0, '0);
    checks++;
    if (out_w !== 5'b0 || in_full !== 5'b0) begin
      failures++;
      $display("FAIL bp_dropped got w=%b full=%b exp 00000/00000", out_w, in_full);
    end
  endtask

  task automatic test_invalid();
    apply_reset();
    cycle(5'b00100, put(2, 8'h15), '0);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL inv_early got err=%b exp 0", err);
    end
    for (int c = 0; c < 3; c++) begin
      cycle('0, '0, '0);
      checks++;
      if (out_w !== 5'b0 || err !== 1'b1) begin
        failures++;
        $display("FAIL inv_drop c=%0d got w=%b err=%b exp 00000/1", c, out_w, err);
      end
    end
    // Queue must be empty: four more accepted pushes with outputs blocked should fill it exactly.
    for (int n = 0; n < 4; n++) cycle(5'b00100, put(2, 8'hA0), 5'b11111);
    checks++;
    if (in_full[2] !== 1'b1) begin
      failures++;
      $display("FAIL inv_empty got in_full2=%b exp 1", in_full[2]);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    cycle(5'b00011, put(0, 8'hA1) | put(1, 8'h05), 5'b01000);
    cycle(5'b00001, put(0, 8'hA2), 5'b01000);
    cycle(5'b00001, put(0, 8'hA3), 5'b01000);
    cycle('0, '0, '0);
    checks++;
    if (out_w !== 5'b01000 || err !== 1'b1) begin
      failures++;
      $display("FAIL mid_before got w=%b err=%b exp 01000/1", out_w, err);
    end
    #2;
    rt_reset = 1'b1;
    #1;
    checks++;
    if (out_w !== 5'b0 || in_full !== 5'b0 || err !== 1'b0 || out_data !== 40'd0) begin
      failures++;
      $display("FAIL mid_async got w=%b full=%b err=%b d=%h exp zeros", out_w, in_full, err,
               out_data);
    end
    model_reset();
    @(negedge rt_clk);
    rt_reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cycle('0, '0, '0);
      checks++;
      if (out_w !== 5'b0) begin
        failures++;
        $display("FAIL mid_stale c=%0d got w=%b exp 00000", c, out_w);
      end
    end
  endtask

  task automatic test_random();
    logic [4:0]  en;
    logic [39:0] data;
    logic [1:0]  row, col;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      en = 5'($urandom);
      for (int p = 0; p < 5; p++) begin
        row = ($urandom_range(0, 15) == 0) ? 2'd0 : 2'($urandom_range(1, 2));
        col = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(1, 2));
        data[p*8 +: 8] = {row, col, 4'($urandom)};
      end
      cycle(en, data, 5'($urandom) & 5'($urandom));
      checks++;
      if ({out_w, out_data, in_full, err} !== {exp_w, exp_d, exp_full, exp_err}) begin
        failures++;
        $display("FAIL random c=%0d got w=%h d=%h f=%h e=%b exp w=%h d=%h f=%h e=%b", c,
                 out_w, out_data, in_full, err, exp_w, exp_d, exp_full, exp_err);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_local_east();
    test_own_dest();
    test_alternate();
    test_backpressure();
    test_invalid();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
